mem_responder: RTL and testbench

- Memory-side responder on the far end of the MAR/MDR interface.
- Accepts read/write strobes from the CPU control unit, latches the address (from MAR) and write data (from MDR output), and performs the access to an internal RAM array after a configurable wait-state count.
- Returns read data on mdatain for loading into the MDR.
- Signals completion with a one-cycle done pulse; busy covers the whole transaction.

---
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: latched request, wait states, RAM access.
// Optional out-of-range error flag enabled by defining MEM_ERR_EN.
module mem_responder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned ADDR_WIDTH  = 9,
   parameter int unsigned DEPTH       = 512,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] mdr_out,
   output logic [DATA_WIDTH-1:0] mdatain,
   output logic                  done,
   output logic                  busy
`ifdef MEM_ERR_EN
   ,
   output logic                  err
`endif
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
   localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

   logic [1:0]            state;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_data;
   logic                  lat_write;
   logic                  in_range;
   logic [IW-1:0]         idx;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign in_range = ({1'b0, lat_addr} < DEPTH_L);
   assign idx      = lat_addr[IW-1:0];

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= S_IDLE;
         cnt       <= '0;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_write <= 1'b0;
         mdatain   <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (read || write) begin
                  lat_addr  <= address;
                  lat_data  <= mdr_out;
                  // read has priority when both strobes are raised together
                  lat_write <= write && !read;
                  busy      <= 1'b1;
                  cnt       <= '0;
                  state     <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end
            end
            S_WAIT: begin
               if (cnt == WAIT_LAST) begin
                  cnt   <= '0;
                  state <= S_ACCESS;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_ACCESS: begin
               if (!lat_write) begin
                  mdatain <= in_range ? mem[idx] : '0;
               end
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array has no reset; an aborted write never reaches S_ACCESS so it is dropped.
   always_ff @(posedge clock) begin
      if (state == S_ACCESS && lat_write && in_range) begin
         mem[idx] <= lat_data;
      end
   end

`ifdef MEM_ERR_EN
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         err <= 1'b0;
      end else begin
         err <= (state == S_ACCESS) && !in_range;
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2/DEPTH=256 instance and a WAIT_CYCLES=0 instance.
module tb_mem_responder;

   logic        clock;
   logic        clear;

   logic        rd_a, wr_a, done_a, busy_a;
   logic [8:0]  addr_a;
   logic [31:0] dout_a, din_a;
`ifdef MEM_ERR_EN
   logic        err_a, err_b;
`endif

   logic        rd_b, wr_b, done_b, busy_b;
   logic [8:0]  addr_b;
   logic [31:0] dout_b, din_b;

   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] q;

   mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (9),
      .DEPTH      (256),
      .WAIT_CYCLES(2)
   ) u_dut_a (
      .clock  (clock),
      .clear  (clear),
      .read   (rd_a),
      .write  (wr_a),
      .address(addr_a),
      .mdr_out(dout_a),
      .mdatain(din_a),
      .done   (done_a),
      .busy   (busy_a)
`ifdef MEM_ERR_EN
      ,
      .err    (err_a)
`endif
   );

   mem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (9),
      .DEPTH      (512),
      .WAIT_CYCLES(0)
   ) u_dut_b (
      .clock  (clock),
      .clear  (clear),
      .read   (rd_b),
      .write  (wr_b),
      .address(addr_b),
      .mdr_out(dout_b),
      .mdatain(din_b),
      .done   (done_b),
      .busy   (busy_b)
`ifdef MEM_ERR_EN
      ,
      .err    (err_b)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One transaction on instance A; inputs are scrambled after acceptance to prove latching.
   task automatic xact_a(input logic rd, input logic wr, input logic [8:0] ad,
                         input logic [31:0] dt, input string tag, output logic [31:0] rv);
      rd_a = rd; wr_a = wr; addr_a = ad; dout_a = dt;
      tick();
      rd_a = 1'b0; wr_a = 1'b0; addr_a = ~ad; dout_a = ~dt;
      rv = '0;
      for (int k = 0; k <= 4; k++) begin
         if (k > 0) tick();
         check($sformatf("%s_done_e%0d", tag, k), {31'b0, done_a}, {31'b0, k == 3});
         check($sformatf("%s_busy_e%0d", tag, k), {31'b0, busy_a}, {31'b0, k < 4});
`ifdef MEM_ERR_EN
         check($sformatf("%s_err_e%0d", tag, k), {31'b0, err_a}, {31'b0, (k == 3) && (ad >= 9'd256)});
`endif
         if (k == 3) rv = din_a;
      end
   endtask

   task automatic write_b(input logic [8:0] ad, input logic [31:0] dt);
      rd_b = 1'b0; wr_b = 1'b1; addr_b = ad; dout_b = dt;
      tick();
      wr_b = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      clear = 1'b0;
      rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; dout_a = '0;
      rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; dout_b = '0;

      tick();
      tick();
      check("rst_done", {31'b0, done_a}, 32'd0);
      check("rst_busy", {31'b0, busy_a}, 32'd0);
      check("rst_mdatain", din_a, 32'd0);
`ifdef MEM_ERR_EN
      check("rst_err", {31'b0, err_a}, 32'd0);
`endif
      clear = 1'b1;
      tick();

      // Write then read back with full edge-by-edge timing checks
      xact_a(1'b0, 1'b1, 9'd10, 32'h1234_5678, "wr10", q);
      xact_a(1'b1, 1'b0, 9'd10, 32'h0, "rd10", q);
      check("rd10_data", q, 32'h1234_5678);

      // Simultaneous strobes: read wins, stored word survives
      xact_a(1'b0, 1'b1, 9'd20, 32'hA5A5_A5A5, "wr20", q);
      xact_a(1'b1, 1'b1, 9'd20, 32'hFFFF_FFFF, "rw20", q);
      check("rw20_data", q, 32'hA5A5_A5A5);
      xact_a(1'b1, 1'b0, 9'd20, 32'h0, "rd20", q);
      check("rd20_data", q, 32'hA5A5_A5A5);

      // mdatain holds across an intervening write
      xact_a(1'b0, 1'b1, 9'd30, 32'h0BAD_F00D, "wr30", q);
      check("hold_mdatain", din_a, 32'hA5A5_A5A5);
      xact_a(1'b1, 1'b0, 9'd30, 32'h0, "rd30", q);
      check("rd30_data", q, 32'h0BAD_F00D);

      // Out of range: read returns 0, write does not alias onto addr 300 mod 256 = 44
      xact_a(1'b0, 1'b1, 9'd44, 32'h4444_4444, "wr44", q);
      xact_a(1'b0, 1'b1, 9'd300, 32'h9999_9999, "wr300", q);
      xact_a(1'b1, 1'b0, 9'd300, 32'h0, "rd300", q);
      check("rd300_data", q, 32'h0);
      xact_a(1'b1, 1'b0, 9'd44, 32'h0, "rd44", q);
      check("rd44_data", q, 32'h4444_4444);

      // Reset during WAIT of a write aborts it
      xact_a(1'b0, 1'b1, 9'd5, 32'h1111_1111, "wr5", q);
      xact_a(1'b1, 1'b0, 9'd5, 32'h0, "rd5a", q);
      rd_a = 1'b0; wr_a = 1'b1; addr_a = 9'd5; dout_a = 32'hDEAD_BEEF;
      tick();
      wr_a = 1'b0;
      tick();
      #2 clear = 1'b0;
      #1;
      check("mid_rst_done", {31'b0, done_a}, 32'd0);
      check("mid_rst_busy", {31'b0, busy_a}, 32'd0);
      check("mid_rst_mdatain", din_a, 32'd0);
      tick();
      clear = 1'b1;
      tick();
      xact_a(1'b1, 1'b0, 9'd5, 32'h0, "rd5b", q);
      check("rd5_after_rst", q, 32'h1111_1111);

      // Zero wait states, held strobe: second request accepted at edge 3
      write_b(9'd7, 32'hCAFE_F00D);
      write_b(9'd8, 32'h8888_8888);
      rd_b = 1'b1; addr_b = 9'd7;
      tick();
      check("b_e0_busy", {31'b0, busy_b}, 32'd1);
      check("b_e0_done", {31'b0, done_b}, 32'd0);
      addr_b = 9'd8;
      tick();
      check("b_e1_done", {31'b0, done_b}, 32'd1);
      check("b_e1_data", din_b, 32'hCAFE_F00D);
      tick();
      check("b_e2_done", {31'b0, done_b}, 32'd0);
      check("b_e2_busy", {31'b0, busy_b}, 32'd0);
      tick();
      check("b_e3_busy", {31'b0, busy_b}, 32'd1);
      check("b_e3_done", {31'b0, done_b}, 32'd0);
      rd_b = 1'b0;
      tick();
      check("b_e4_done", {31'b0, done_b}, 32'd1);
      check("b_e4_data", din_b, 32'h8888_8888);
      tick();
      check("b_e5_done", {31'b0, done_b}, 32'd0);
      check("b_e5_busy", {31'b0, busy_b}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
